// File: rtl/tree_mac_scheduler.sv
// Tile sequencer and result FIFO for the tree MAC datapath. Walks an I x K tile
// row-major, issues operand reads one cycle ahead of MAC beats, and holds results
// in a credit-protected FIFO so the non-stallable MAC can never overrun it.
module tree_mac_scheduler #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DATA_LENGTH     = 64,
  parameter int unsigned TREE_BASE       = 2,
  parameter int unsigned ADDRESS_WIDTH_I = 8,
  parameter int unsigned ADDRESS_WIDTH_K = 8,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDRESS_WIDTH_I:0]     cfg_num_i,
  input  logic [ADDRESS_WIDTH_K:0]     cfg_num_k,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDRESS_WIDTH_I-1:0]   rd_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0]   rd_addr_k,
  output logic                         mac_val_in,
  output logic [ADDRESS_WIDTH_I-1:0]   mac_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0]   mac_addr_k,
  input  logic                         mac_val_out,
  input  logic [ADDRESS_WIDTH_I-1:0]   mac_addr_i_out,
  input  logic [ADDRESS_WIDTH_K-1:0]   mac_addr_k_out,
  input  logic [4*DATA_WIDTH-1:0]      mac_sum,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ADDRESS_WIDTH_I-1:0]   res_addr_i,
  output logic [ADDRESS_WIDTH_K-1:0]   res_addr_k,
  output logic [4*DATA_WIDTH-1:0]      res_sum
);

  // Ceiling logarithm in an arbitrary base: depth of the MAC adder tree.
  function automatic int unsigned clog_base(int unsigned value, int unsigned base);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    for (int unsigned n = 0; n < 32; n++) begin
      if (p < value) begin
        p = p * base;
        r = r + 1;
      end
    end
    return r;
  endfunction

  localparam int unsigned Lat    = clog_base(DATA_LENGTH, TREE_BASE) + 2;
  localparam int unsigned SumW   = 4 * DATA_WIDTH;
  localparam int unsigned CredW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FlushW = $clog2(Lat + 1);
  localparam int unsigned EntW   = ADDRESS_WIDTH_I + ADDRESS_WIDTH_K + SumW;

  localparam logic [CredW-1:0] CredFull = CredW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StFlush, StIdle, StRun, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [FlushW-1:0]            flush_q, flush_d;
  logic [ADDRESS_WIDTH_I-1:0]   i_q, i_d;
  logic [ADDRESS_WIDTH_K-1:0]   k_q, k_d;
  logic [ADDRESS_WIDTH_I:0]     num_i_q, num_i_d;
  logic [ADDRESS_WIDTH_K:0]     num_k_q, num_k_d;
  logic [CredW-1:0]             credits_q, credits_d;
  logic                         done_q, done_d;
  logic                         mac_val_q;
  logic [ADDRESS_WIDTH_I-1:0]   mac_addr_i_q;
  logic [ADDRESS_WIDTH_K-1:0]   mac_addr_k_q;
  logic [EntW-1:0]              mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CredW-1:0]             count_q;
  logic                         issue, push, pop;
  logic                         last_i, last_k;

  assign issue  = (state_q == StRun) && (credits_q != '0);
  assign push   = mac_val_out && (state_q != StFlush);
  assign pop    = (count_q != '0) && res_ready;
  assign last_i = ({1'b0, i_q} == num_i_q - (ADDRESS_WIDTH_I + 1)'(1));
  assign last_k = ({1'b0, k_q} == num_k_q - (ADDRESS_WIDTH_K + 1)'(1));

  // Credits track free FIFO slots minus beats still in flight through the MAC.
  always_comb begin
    credits_d = credits_q;
    unique case ({issue, pop})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Next-state logic: flush wait, cfg latch, row-major walk, drain.
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    i_d     = i_q;
    k_d     = k_q;
    num_i_d = num_i_q;
    num_k_d = num_k_q;
    done_d  = 1'b0;
    unique case (state_q)
      StFlush: begin
        if (flush_q == FlushW'(Lat)) state_d = StIdle;
        else                         flush_d = flush_q + FlushW'(1);
      end
      StIdle: begin
        if (start) begin
          num_i_d = cfg_num_i;
          num_k_d = cfg_num_k;
          i_d     = '0;
          k_d     = '0;
          if (cfg_num_i == '0 || cfg_num_k == '0) done_d  = 1'b1;
          else                                    state_d = StRun;
        end
      end
      StRun: begin
        if (issue) begin
          if (last_k) begin
            k_d = '0;
            if (last_i) state_d = StDrain;
            else        i_d     = i_q + ADDRESS_WIDTH_I'(1);
          end else begin
            k_d = k_q + ADDRESS_WIDTH_K'(1);
          end
        end
      end
      StDrain: begin
        if (credits_d == CredFull) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StFlush;
    endcase
  end

  // Control state; reset lands in FLUSH so stale MAC beats are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFlush;
      flush_q   <= '0;
      i_q       <= '0;
      k_q       <= '0;
      num_i_q   <= '0;
      num_k_q   <= '0;
      credits_q <= CredFull;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      i_q       <= i_d;
      k_q       <= k_d;
      num_i_q   <= num_i_d;
      num_k_q   <= num_k_d;
      credits_q <= credits_d;
      done_q    <= done_d;
    end
  end

  // MAC issue stage: one cycle behind the operand read; addresses hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_val_q    <= 1'b0;
      mac_addr_i_q <= '0;
      mac_addr_k_q <= '0;
    end else begin
      mac_val_q <= issue;
      if (issue) begin
        mac_addr_i_q <= i_q;
        mac_addr_k_q <= k_q;
      end
    end
  end

  // Result FIFO, registered head (not fall-through).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < FIFO_DEPTH; n++) mem_q[n] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {mac_addr_i_out, mac_addr_k_out, mac_sum};
        wr_ptr_q        <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CredW'(1);
        2'b01:   count_q <= count_q - CredW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // busy is qualified by reset so it reads 0 while reset is held, even in FLUSH.
  assign busy       = reset && (state_q != StIdle);
  assign done       = done_q;
  assign rd_en      = issue;
  assign rd_addr_i  = i_q;
  assign rd_addr_k  = k_q;
  assign mac_val_in = mac_val_q;
  assign mac_addr_i = mac_addr_i_q;
  assign mac_addr_k = mac_addr_k_q;
  assign res_valid  = (count_q != '0);
  assign {res_addr_i, res_addr_k, res_sum} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_tree_mac_scheduler.sv
// Directed bench for tree_mac_scheduler: two instances (FIFO depth 16 and 4)
// driven against a behavioural operand buffer + fixed-latency MAC model.
module tb_tree_mac_scheduler;

  localparam int DW  = 8;
  localparam int LEN = 64;
  localparam int AWI = 8;
  localparam int AWK = 8;
  localparam int LAT = 8;  // clog2(64) + 2

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             start          [2];
  logic [AWI:0]     cfg_num_i      [2];
  logic [AWK:0]     cfg_num_k      [2];
  logic             busy           [2];
  logic             done           [2];
  logic             rd_en          [2];
  logic [AWI-1:0]   rd_addr_i      [2];
  logic [AWK-1:0]   rd_addr_k      [2];
  logic             mac_val_in     [2];
  logic [AWI-1:0]   mac_addr_i     [2];
  logic [AWK-1:0]   mac_addr_k     [2];
  logic             mac_val_out    [2];
  logic [AWI-1:0]   mac_addr_i_out [2];
  logic [AWK-1:0]   mac_addr_k_out [2];
  logic [4*DW-1:0]  mac_sum        [2];
  logic             res_valid      [2];
  logic             res_ready      [2];
  logic [AWI-1:0]   res_addr_i     [2];
  logic [AWK-1:0]   res_addr_k     [2];
  logic [4*DW-1:0]  res_sum        [2];

  int nvec = 0;
  int nerr = 0;

  tree_mac_scheduler #(.DATA_WIDTH(DW), .DATA_LENGTH(LEN), .TREE_BASE(2),
    .ADDRESS_WIDTH_I(AWI), .ADDRESS_WIDTH_K(AWK), .FIFO_DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start[0]), .cfg_num_i(cfg_num_i[0]),
    .cfg_num_k(cfg_num_k[0]), .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]),
    .rd_addr_i(rd_addr_i[0]), .rd_addr_k(rd_addr_k[0]), .mac_val_in(mac_val_in[0]),
    .mac_addr_i(mac_addr_i[0]), .mac_addr_k(mac_addr_k[0]), .mac_val_out(mac_val_out[0]),
    .mac_addr_i_out(mac_addr_i_out[0]), .mac_addr_k_out(mac_addr_k_out[0]),
    .mac_sum(mac_sum[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_addr_i(res_addr_i[0]), .res_addr_k(res_addr_k[0]), .res_sum(res_sum[0]));

  tree_mac_scheduler #(.DATA_WIDTH(DW), .DATA_LENGTH(LEN), .TREE_BASE(2),
    .ADDRESS_WIDTH_I(AWI), .ADDRESS_WIDTH_K(AWK), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start[1]), .cfg_num_i(cfg_num_i[1]),
    .cfg_num_k(cfg_num_k[1]), .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]),
    .rd_addr_i(rd_addr_i[1]), .rd_addr_k(rd_addr_k[1]), .mac_val_in(mac_val_in[1]),
    .mac_addr_i(mac_addr_i[1]), .mac_addr_k(mac_addr_k[1]), .mac_val_out(mac_val_out[1]),
    .mac_addr_i_out(mac_addr_i_out[1]), .mac_addr_k_out(mac_addr_k_out[1]),
    .mac_sum(mac_sum[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_addr_i(res_addr_i[1]), .res_addr_k(res_addr_k[1]), .res_sum(res_sum[1]));

  // Operand buffers (1-cycle read) and an unreset LAT-stage MAC pipeline.
  logic [7:0]      row_mem [256];
  logic [7:0]      col_mem [256];
  logic [7:0]      row_data [2];
  logic [7:0]      col_data [2];
  logic            pv [2][LAT];
  logic [AWI-1:0]  pi [2][LAT];
  logic [AWK-1:0]  pk [2][LAT];
  logic [4*DW-1:0] ps [2][LAT];

  initial begin
    for (int u = 0; u < 2; u++) begin
      row_data[u] = 8'd0;
      col_data[u] = 8'd0;
      for (int s = 0; s < LAT; s++) begin
        pv[u][s] = 1'b0; pi[u][s] = '0; pk[u][s] = '0; ps[u][s] = '0;
      end
    end
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rd_en[u]) begin
        row_data[u] <= row_mem[rd_addr_i[u]];
        col_data[u] <= col_mem[rd_addr_k[u]];
      end
      pv[u][0] <= mac_val_in[u];
      pi[u][0] <= mac_addr_i[u];
      pk[u][0] <= mac_addr_k[u];
      ps[u][0] <= 32'(LEN) * {24'd0, row_data[u]} * {24'd0, col_data[u]};
      for (int s = 1; s < LAT; s++) begin
        pv[u][s] <= pv[u][s-1];
        pi[u][s] <= pi[u][s-1];
        pk[u][s] <= pk[u][s-1];
        ps[u][s] <= ps[u][s-1];
      end
    end
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      mac_val_out[u]    = pv[u][LAT-1];
      mac_addr_i_out[u] = pi[u][LAT-1];
      mac_addr_k_out[u] = pk[u][LAT-1];
      mac_sum[u]        = ps[u][LAT-1];
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if ({busy[u], done[u], rd_en[u], rd_addr_i[u], rd_addr_k[u], mac_val_in[u],
           mac_addr_i[u], mac_addr_k[u], res_valid[u], res_addr_i[u], res_addr_k[u],
           res_sum[u]} !== '0) begin
        nerr++;
        $display("FAIL reset_outputs dut%0d: busy=%b done=%b rd_en=%b res_valid=%b, all must be 0",
                 u, busy[u], done[u], rd_en[u], res_valid[u]);
      end
    end
    reset = 1'b1;
    #1;
    for (int j = 0; j <= LAT; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      for (int u = 0; u < 2; u++) begin
        nvec++;
        if (busy[u] !== 1'b1 || res_valid[u] !== 1'b0) begin
          nerr++;
          $display("FAIL flush_busy dut%0d cyc %0d: busy=%b res_valid=%b, need 1/0",
                   u, j, busy[u], res_valid[u]);
        end
      end
    end
    @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if (busy[u] !== 1'b0) begin
        nerr++;
        $display("FAIL flush_exit dut%0d: busy=%b, need 0", u, busy[u]);
      end
    end
  endtask

  task automatic test_tile_2x3();
    int n_iss = 0;
    int n_res = 0;
    res_ready[0] = 1'b1;
    start[0] = 1'b1; cfg_num_i[0] = 9'd2; cfg_num_k[0] = 9'd3;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      nvec++;
      if (rd_en[0] !== (c >= 1 && c <= 6)) begin
        nerr++; $display("FAIL tile_rd_en cyc %0d: got %b", c, rd_en[0]);
      end
      if (rd_en[0] === 1'b1) begin
        nvec++;
        if (rd_addr_i[0] !== AWI'(n_iss / 3) || rd_addr_k[0] !== AWK'(n_iss % 3)) begin
          nerr++;
          $display("FAIL tile_rd_addr #%0d: got (%0d,%0d) need (%0d,%0d)", n_iss,
                   rd_addr_i[0], rd_addr_k[0], n_iss / 3, n_iss % 3);
        end
        n_iss++;
      end
      nvec++;
      if (res_valid[0] !== (c >= 11 && c <= 16)) begin
        nerr++; $display("FAIL tile_res_valid cyc %0d: got %b", c, res_valid[0]);
      end
      if (res_valid[0] === 1'b1) begin
        nvec++;
        if (res_addr_i[0] !== AWI'(n_res / 3) || res_addr_k[0] !== AWK'(n_res % 3) ||
            res_sum[0] !== 32'd128) begin
          nerr++;
          $display("FAIL tile_result #%0d: got (%0d,%0d) sum %0d need (%0d,%0d) sum 128",
                   n_res, res_addr_i[0], res_addr_k[0], res_sum[0], n_res / 3, n_res % 3);
        end
        n_res++;
      end
      nvec++;
      if (done[0] !== (c == 17) || busy[0] !== (c <= 16)) begin
        nerr++;
        $display("FAIL tile_done_busy cyc %0d: done=%b busy=%b", c, done[0], busy[0]);
      end
    end
  endtask

  task automatic test_zero_tile();
    for (int v = 0; v < 2; v++) begin
      start[0] = 1'b1;
      cfg_num_i[0] = (v == 0) ? 9'd0 : 9'd2;
      cfg_num_k[0] = (v == 0) ? 9'd3 : 9'd0;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk); #1;
        start[0] = 1'b0;
        nvec++;
        if (done[0] !== (c == 1) || busy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin
          nerr++;
          $display("FAIL zero_tile v%0d cyc %0d: done=%b busy=%b rd_en=%b", v, c,
                   done[0], busy[0], rd_en[0]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    int n_iss = 0;
    int n_res = 0;
    start[0] = 1'b1; cfg_num_i[0] = 9'd1; cfg_num_k[0] = 9'd4;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start[0] = (c == 2);
      if (c == 2) begin cfg_num_i[0] = 9'd3; cfg_num_k[0] = 9'd3; end
      nvec++;
      if (rd_en[0] !== (c >= 1 && c <= 4)) begin
        nerr++; $display("FAIL ign_rd_en cyc %0d: got %b", c, rd_en[0]);
      end
      if (rd_en[0] === 1'b1) begin
        nvec++;
        if (rd_addr_i[0] !== 8'd0 || rd_addr_k[0] !== AWK'(n_iss)) begin
          nerr++;
          $display("FAIL ign_rd_addr #%0d: got (%0d,%0d)", n_iss, rd_addr_i[0], rd_addr_k[0]);
        end
        n_iss++;
      end
      nvec++;
      if (res_valid[0] !== (c >= 11 && c <= 14)) begin
        nerr++; $display("FAIL ign_res_valid cyc %0d: got %b", c, res_valid[0]);
      end
      if (res_valid[0] === 1'b1) begin
        nvec++;
        if (res_addr_i[0] !== 8'd0 || res_addr_k[0] !== AWK'(n_res) || res_sum[0] !== 32'd128)
        begin
          nerr++;
          $display("FAIL ign_result #%0d: got (%0d,%0d) sum %0d", n_res, res_addr_i[0],
                   res_addr_k[0], res_sum[0]);
        end
        n_res++;
      end
      nvec++;
      if (done[0] !== (c == 15) || busy[0] !== (c <= 14)) begin
        nerr++; $display("FAIL ign_done_busy cyc %0d: done=%b busy=%b", c, done[0], busy[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n_iss = 0;
    int n_res = 0;
    int n_done = 0;
    bit seen_done = 1'b0;
    for (int k = 0; k < 8; k++) col_mem[k] = 8'(k + 1);
    res_ready[1] = 1'b0;
    start[1] = 1'b1; cfg_num_i[1] = 9'd1; cfg_num_k[1] = 9'd8;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start[1] = 1'b0;
      nvec++;
      if (rd_en[1] !== (c <= 4)) begin
        nerr++; $display("FAIL bp_rd_en cyc %0d: got %b", c, rd_en[1]);
      end
      if (rd_en[1] === 1'b1) n_iss++;
      nvec++;
      if (res_valid[1] !== (c >= 11)) begin
        nerr++; $display("FAIL bp_res_valid cyc %0d: got %b", c, res_valid[1]);
      end
    end
    nvec++;
    if (res_addr_k[1] !== 8'd0 || res_sum[1] !== 32'd64) begin
      nerr++;
      $display("FAIL bp_head: got k=%0d sum=%0d need k=0 sum=64", res_addr_k[1], res_sum[1]);
    end
    for (int c = 0; c < 100 && !seen_done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      res_ready[1] = 1'b1;
      if (rd_en[1] === 1'b1) begin
        nvec++;
        if (rd_addr_k[1] !== AWK'(n_iss)) begin
          nerr++; $display("FAIL bp_rd_addr #%0d: got k=%0d", n_iss, rd_addr_k[1]);
        end
        n_iss++;
      end
      if (res_valid[1] === 1'b1) begin
        nvec++;
        if (res_addr_i[1] !== 8'd0 || res_addr_k[1] !== AWK'(n_res) ||
            res_sum[1] !== 32'(64 * (n_res + 1))) begin
          nerr++;
          $display("FAIL bp_result #%0d: got (%0d,%0d) sum %0d need (0,%0d) sum %0d", n_res,
                   res_addr_i[1], res_addr_k[1], res_sum[1], n_res, 64 * (n_res + 1));
        end
        n_res++;
      end
      if (done[1] === 1'b1) begin n_done++; seen_done = 1'b1; end
    end
    nvec++;
    if (n_iss != 8 || n_res != 8 || n_done != 1) begin
      nerr++;
      $display("FAIL bp_totals: issues=%0d results=%0d done=%0d need 8/8/1", n_iss, n_res, n_done);
    end
    res_ready[1] = 1'b0;
    for (int k = 0; k < 8; k++) col_mem[k] = 8'd2;
  endtask

  task automatic test_reset_mid_run();
    start[0] = 1'b1; cfg_num_i[0] = 9'd2; cfg_num_k[0] = 9'd3;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      nvec++;
      if (rd_en[0] !== 1'b1) begin
        nerr++; $display("FAIL mid_rd_en cyc %0d: got %b need 1", c, rd_en[0]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if ({busy[u], done[u], rd_en[u], rd_addr_i[u], rd_addr_k[u], mac_val_in[u],
           mac_addr_i[u], mac_addr_k[u], res_valid[u], res_addr_i[u], res_addr_k[u],
           res_sum[u]} !== '0) begin
        nerr++;
        $display("FAIL mid_reset_outputs dut%0d: busy=%b rd_en=%b mac_val_in=%b mac_addr_k=%0d",
                 u, busy[u], rd_en[u], mac_val_in[u], mac_addr_k[u]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    for (int j = 0; j <= LAT + 5; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      nvec++;
      if (busy[0] !== (j <= LAT) || res_valid[0] !== 1'b0 || done[0] !== 1'b0) begin
        nerr++;
        $display("FAIL mid_flush cyc %0d: busy=%b res_valid=%b done=%b", j, busy[0],
                 res_valid[0], done[0]);
      end
    end
    start[0] = 1'b1; cfg_num_i[0] = 9'd1; cfg_num_k[0] = 9'd1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      nvec++;
      if (rd_en[0] !== (c == 1) || res_valid[0] !== (c == 11) || done[0] !== (c == 12)) begin
        nerr++;
        $display("FAIL post_tile cyc %0d: rd_en=%b res_valid=%b done=%b", c, rd_en[0],
                 res_valid[0], done[0]);
      end
      if (res_valid[0] === 1'b1) begin
        nvec++;
        if (res_addr_i[0] !== 8'd0 || res_addr_k[0] !== 8'd0 || res_sum[0] !== 32'd128) begin
          nerr++;
          $display("FAIL post_result: got (%0d,%0d) sum %0d need (0,0) sum 128",
                   res_addr_i[0], res_addr_k[0], res_sum[0]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      row_mem[a] = 8'd1;
      col_mem[a] = 8'd2;
    end
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; cfg_num_i[u] = '0; cfg_num_k[u] = '0; res_ready[u] = 1'b0;
    end
    test_reset();
    test_tile_2x3();
    test_zero_tile();
    test_ignored_start();
    test_backpressure();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
